// File: rtl/serial_subtractor_8bit_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
// When SUB_SIGNED_OVF_EN is defined, the bundle also carries the signed-overflow flag ovf.
interface serial_subtractor_8bit_if #(
  parameter int unsigned NUM_BITS = 8
);
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                borrow_in;
  logic [NUM_BITS-1:0] diff;
  logic                borrow_out;
  logic                busy;
  logic                done;
`ifdef SUB_SIGNED_OVF_EN
  logic                ovf;
`endif

  // Requester side
  modport master (
    output start, a, b, borrow_in,
    input  diff, borrow_out, busy, done
`ifdef SUB_SIGNED_OVF_EN
    , input ovf
`endif
  );

  // Subtractor side
  modport slave (
    input  start, a, b, borrow_in,
    output diff, borrow_out, busy, done
`ifdef SUB_SIGNED_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Handshake: start is accepted in IDLE, busy is high for NUM_BITS cycles, and done pulses once.
// Optional feature: define SUB_SIGNED_OVF_EN to add the registered signed-overflow flag ovf.
module serial_subtractor_8bit #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_subtractor_8bit_if.slave   bus
);

  localparam int unsigned CW = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [NUM_BITS-1:0] r_a_sr;
  logic [NUM_BITS-1:0] r_b_sr;
  logic [NUM_BITS-1:0] r_res;
  logic [CW-1:0]       r_cnt;
  logic                r_br;
  logic [NUM_BITS-1:0] r_diff;
  logic                r_borrow_out;

  logic                w_d;
  logic                w_br_next;
  logic                w_last;
  logic [NUM_BITS-1:0] w_res_next;

  // Full-subtractor cell for the current bit
  assign w_d        = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
  assign w_br_next  = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);
  assign w_res_next = {w_d, r_res[NUM_BITS-1:1]};
  assign w_last     = (r_cnt == CW'(NUM_BITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = SHIFT;
      SHIFT:   if (w_last)    w_state_next = DONE;
      DONE:                   w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

`ifdef SUB_SIGNED_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand sign bits are kept aside because the shift registers lose them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_a_msb <= bus.a[NUM_BITS-1];
      r_b_msb <= bus.b[NUM_BITS-1];
    end else if (r_state == SHIFT && w_last) begin
      r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  // Operand/result shift datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_res        <= '0;
      r_cnt        <= '0;
      r_br         <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sr <= bus.a;
            r_b_sr <= bus.b;
            r_br   <= bus.borrow_in;
            r_res  <= '0;
            r_cnt  <= '0;
          end
        end
        SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_br   <= w_br_next;
          r_res  <= w_res_next;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff       <= w_res_next;
            r_borrow_out <= w_br_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;
  assign bus.busy       = (r_state == SHIFT);
  assign bus.done       = (r_state == DONE);

endmodule
